// File: rtl/cntr_load_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cntr_load_seq_pkg
// Description : Shared widths, PE state codes and packet types for the
//               controller sequencer and the buffer write decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif
`ifndef ICP_NUM
`define ICP_NUM 4
`endif
`ifndef OCP_NUM
`define OCP_NUM 4
`endif
`ifndef ADDR_B
`define ADDR_B 8
`endif
`ifndef SD
`define SD
`endif

package cntr_load_seq_pkg;

    localparam int c_data_wid = `CNN_XLEN;
    localparam int c_icp_num  = `ICP_NUM;
    localparam int c_ocp_num  = `OCP_NUM;
    localparam int c_addr_b   = `ADDR_B;
    localparam int c_icp_b    = $clog2(c_icp_num);
    localparam int c_ocp_b    = $clog2(c_ocp_num);
    localparam int c_gaddr_b  = c_addr_b + c_icp_b + c_ocp_b;
    localparam int c_len_b    = c_gaddr_b + 1;

    typedef enum logic [2:0] {
        INVALID = 3'd0,
        LOAD    = 3'd1,
        CONV    = 3'd2,
        POOL    = 3'd3,
        RELU    = 3'd4
    } PE_STATE;

    typedef struct packed {
        PE_STATE                PE_state;
        logic                   wrb;
        logic [c_gaddr_b-1:0]   wrb_addr;
        logic [c_data_wid-1:0]  wrb_data;
        logic [c_addr_b-1:0]    rdb_addr;
    } CNTR_PACKET;

    typedef struct packed {
        PE_STATE                                PE_state;
        logic [c_ocp_num-1:0][c_icp_num-1:0]    wr_en;
        logic [c_addr_b-1:0]                    wr_addr;
        logic [c_data_wid-1:0]                  wr_data;
        logic [c_addr_b-1:0]                    rd_addr;
    } DEC_OUT_PACKET;

    // Sequencer FSM encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/cntr_load_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : cntr_load_seq_if
// Description : Command, input-stream and packet bundle of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface cntr_load_seq_if;
    import cntr_load_seq_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [c_gaddr_b-1:0]   cmd_wr_base;
    logic [c_len_b-1:0]     cmd_wr_len;
    logic [c_addr_b-1:0]    cmd_rd_base;
    logic [c_addr_b:0]      cmd_rd_len;
    PE_STATE                cmd_pe_state;
    logic                   in_valid;
    logic                   in_ready;
    logic [c_data_wid-1:0]  in_data;
    CNTR_PACKET             CNTR_pk_out;
    logic                   busy;
    logic                   done;

    modport master (
        output cmd_valid, cmd_wr_base, cmd_wr_len, cmd_rd_base, cmd_rd_len,
               cmd_pe_state, in_valid, in_data,
        input  cmd_ready, in_ready, CNTR_pk_out, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_wr_base, cmd_wr_len, cmd_rd_base, cmd_rd_len,
               cmd_pe_state, in_valid, in_data,
        output cmd_ready, in_ready, CNTR_pk_out, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/cntr_load_seq_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module      : cntr_load_seq_addr_ctr
// Description : Loadable wrapping address counter with a length countdown.
// Revision    : 1.0 - initial release
// ============================================================================
module cntr_load_seq_addr_ctr #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_load,
    input  wire logic [ADDR_W-1:0] i_base,
    input  wire logic [LEN_W-1:0]  i_len,
    input  wire logic              i_step,
    output logic      [ADDR_W-1:0] o_addr,
    output logic                   o_last,
    output logic                   o_empty
);

    localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remain;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_addr   <= i_base;
            r_remain <= i_len;
        end else if (i_step && (r_remain != '0)) begin
            // Address wraps silently at the top of its range
            r_addr   <= r_addr + ADDR_W'(1);
            r_remain <= r_remain - c_one;
        end
    end

    assign o_addr  = r_addr;
    assign o_last  = (r_remain == c_one);
    assign o_empty = (r_remain == '0);

endmodule

`default_nettype wire

// File: rtl/cntr_load_seq.sv
`default_nettype none
// ============================================================================
// Module      : cntr_load_seq
// Description : Command sequencer: loads a word stream into the global buffer,
//               then sweeps read addresses for the PE array.
// Revision    : 1.0 - initial release
// ============================================================================
module cntr_load_seq
    import cntr_load_seq_pkg::*;
#(
    parameter int DATA_WID = `CNN_XLEN,
    parameter int ICP_NUM  = `ICP_NUM,
    parameter int ICP_B    = $clog2(ICP_NUM),
    parameter int OCP_NUM  = `OCP_NUM,
    parameter int OCP_B    = $clog2(OCP_NUM),
    parameter int ADDR_B   = `ADDR_B,
    parameter int GADDR_B  = ADDR_B + ICP_B + OCP_B,
    parameter int LEN_B    = GADDR_B + 1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    cntr_load_seq_if.slave   bus
);

    seq_state_t          r_state;
    seq_state_t          w_next;
    PE_STATE             r_pe_state;
    CNTR_PACKET          r_pk;
    logic                r_done;

    logic                w_cmd_ready;
    logic                w_in_ready;
    logic                w_cmd_fire;
    logic                w_beat;
    logic                w_rd_step;
    logic [GADDR_B-1:0]  w_wr_addr;
    logic                w_wr_last;
    logic                w_wr_empty;
    logic [ADDR_B-1:0]   w_rd_addr;
    logic                w_rd_last;
    logic                w_rd_empty;

    assign w_cmd_ready = (r_state == S_IDLE);
    assign w_in_ready  = (r_state == S_LOAD) && !w_wr_empty;
    assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
    assign w_beat      = bus.in_valid && w_in_ready;
    assign w_rd_step   = (r_state == S_RUN);

    cntr_load_seq_addr_ctr #(
        .ADDR_W (GADDR_B),
        .LEN_W  (LEN_B)
    ) u_wr_ctr (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_cmd_fire),
        .i_base  (bus.cmd_wr_base),
        .i_len   (bus.cmd_wr_len),
        .i_step  (w_beat),
        .o_addr  (w_wr_addr),
        .o_last  (w_wr_last),
        .o_empty (w_wr_empty)
    );

    cntr_load_seq_addr_ctr #(
        .ADDR_W (ADDR_B),
        .LEN_W  (ADDR_B + 1)
    ) u_rd_ctr (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_cmd_fire),
        .i_base  (bus.cmd_rd_base),
        .i_len   (bus.cmd_rd_len),
        .i_step  (w_rd_step),
        .o_addr  (w_rd_addr),
        .o_last  (w_rd_last),
        .o_empty (w_rd_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    if (bus.cmd_wr_len != '0)      w_next = S_LOAD;
                    else if (bus.cmd_rd_len != '0) w_next = S_RUN;
                    else                           w_next = S_DONE;
                end
            end
            S_LOAD: begin
                if (w_beat && w_wr_last) w_next = w_rd_empty ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_rd_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Packet fields are registered one cycle behind the state that produces them
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pk       <= '0;
            r_done     <= 1'b0;
            r_pe_state <= INVALID;
        end else begin
            r_done   <= (r_state == S_DONE);
            r_pk.wrb <= 1'b0;
            if (w_cmd_fire) r_pe_state <= bus.cmd_pe_state;
            case (r_state)
                S_LOAD: begin
                    if (w_beat) begin
                        r_pk.wrb      <= 1'b1;
                        r_pk.wrb_addr <= w_wr_addr;
                        r_pk.wrb_data <= bus.in_data;
                        r_pk.PE_state <= LOAD;
                    end
                end
                S_RUN: begin
                    r_pk.PE_state <= r_pe_state;
                    r_pk.rdb_addr <= w_rd_addr;
                end
                S_DONE:  r_pk.PE_state <= INVALID;
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.in_ready    = w_in_ready;
    assign bus.CNTR_pk_out = r_pk;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_cntr_load_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cntr_load_seq
// Description : Scoreboard bench for the load/run command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cntr_load_seq;
    import cntr_load_seq_pkg::*;

    localparam int c_k_wr   = 0;
    localparam int c_k_rd   = 1;
    localparam int c_k_done = 2;

    typedef struct {
        int          kind;
        logic [11:0] addr;
        logic [15:0] data;
        PE_STATE     pe;
    } exp_t;

    logic clk;
    logic reset;
    logic r_mon_en;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    cntr_load_seq_if bus_if ();

    cntr_load_seq u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe visible packet events and pop the matching expectation
    always @(negedge clk) begin : mon
        exp_t e;
        int   k;
        logic ev;
        if (r_mon_en) begin
            ev = 1'b1;
            k  = c_k_wr;
            if (bus_if.CNTR_pk_out.wrb === 1'b1)           k = c_k_wr;
            else if (bus_if.done === 1'b1)                 k = c_k_done;
            else if (bus_if.CNTR_pk_out.PE_state != INVALID &&
                     bus_if.CNTR_pk_out.PE_state != LOAD)  k = c_k_rd;
            else                                           ev = 1'b0;
            if (ev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 64'(k + 16), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", 64'(k), 64'(e.kind));
                    if (k == c_k_wr) begin
                        chk("wr_addr", 64'(bus_if.CNTR_pk_out.wrb_addr), 64'(e.addr));
                        chk("wr_data", 64'(bus_if.CNTR_pk_out.wrb_data), 64'(e.data));
                        chk("wr_pe",   64'(bus_if.CNTR_pk_out.PE_state), 64'(LOAD));
                    end else if (k == c_k_rd) begin
                        chk("rd_addr", 64'(bus_if.CNTR_pk_out.rdb_addr), 64'(e.addr[7:0]));
                        chk("rd_pe",   64'(bus_if.CNTR_pk_out.PE_state), 64'(e.pe));
                    end else begin
                        chk("done_pe", 64'(bus_if.CNTR_pk_out.PE_state), 64'(INVALID));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [11:0] wb, input int wl, input logic [7:0] rb,
                          input int rl, input PE_STATE pe, input logic [15:0] d0,
                          input int n_wr_exp, input bit exp_done);
        exp_t e;
        int   cyc;
        for (int i = 0; i < n_wr_exp; i++) begin
            e.kind = c_k_wr; e.addr = 12'(wb + 12'(i)); e.data = 16'(d0 + 16'(i)); e.pe = LOAD;
            sb.push_back(e);
        end
        if (exp_done) begin
            for (int i = 0; i < rl; i++) begin
                e.kind = c_k_rd; e.addr = 12'(8'(rb + 8'(i))); e.data = '0; e.pe = pe;
                sb.push_back(e);
            end
            e.kind = c_k_done; e.addr = '0; e.data = '0; e.pe = INVALID;
            sb.push_back(e);
        end
        cyc = 0;
        while (bus_if.cmd_ready !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("cmd_ready_wait", 64'(bus_if.cmd_ready), 64'(1));
        bus_if.cmd_valid    = 1'b1;
        bus_if.cmd_wr_base  = wb;
        bus_if.cmd_wr_len   = 13'(wl);
        bus_if.cmd_rd_base  = rb;
        bus_if.cmd_rd_len   = 9'(rl);
        bus_if.cmd_pe_state = pe;
        step();
        bus_if.cmd_valid    = 1'b0;
    endtask

    // Offer beats following a repeating valid pattern until n are accepted
    task automatic stream(input logic [15:0] d0, input int n, input logic [15:0] pat, input int plen);
        int   idx;
        int   cyc;
        logic acc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            bus_if.in_valid = pat[cyc % plen];
            bus_if.in_data  = 16'(d0 + 16'(idx));
            acc = bus_if.in_valid && (bus_if.in_ready === 1'b1);
            step();
            if (acc) idx++;
            cyc++;
        end
        bus_if.in_valid = 1'b0;
        chk("stream_beats", 64'(idx), 64'(n));
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("drain_left", 64'(sb.size()), 64'(0));
        step();
        chk("idle_cmd_ready", 64'(bus_if.cmd_ready), 64'(1));
        chk("idle_busy",      64'(bus_if.busy),      64'(0));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        r_mon_en = 1'b0;
        reset    = 1'b1;
        bus_if.cmd_valid    = 1'b0;
        bus_if.cmd_wr_base  = '0;
        bus_if.cmd_wr_len   = '0;
        bus_if.cmd_rd_base  = '0;
        bus_if.cmd_rd_len   = '0;
        bus_if.cmd_pe_state = INVALID;
        bus_if.in_valid     = 1'b0;
        bus_if.in_data      = '0;
        repeat (3) step();
        chk("rst_pk",        64'(bus_if.CNTR_pk_out), 64'(0));
        chk("rst_done",      64'(bus_if.done),        64'(0));
        chk("rst_busy",      64'(bus_if.busy),        64'(0));
        chk("rst_cmd_ready", 64'(bus_if.cmd_ready),   64'(1));
        chk("rst_in_ready",  64'(bus_if.in_ready),    64'(0));
        reset    = 1'b0;
        r_mon_en = 1'b1;
        step();

        // Basic load, done one cycle after the last visible write
        do_cmd(12'h00E, 4, 8'h00, 0, INVALID, 16'h00A1, 4, 1'b1);
        stream(16'h00A1, 4, 16'hFFFF, 1);
        chk("last_wrb",       64'(bus_if.CNTR_pk_out.wrb), 64'(1));
        chk("in_ready_after", 64'(bus_if.in_ready),        64'(0));
        step();
        chk("done_after_last", 64'(bus_if.done), 64'(1));
        drain();

        // Gapped stream 1,0,0,1,0,1 with stray in_valid afterwards
        do_cmd(12'h020, 3, 8'h00, 0, INVALID, 16'h00B1, 3, 1'b1);
        stream(16'h00B1, 3, 16'b101001, 6);
        bus_if.in_valid = 1'b1;
        drain();
        bus_if.in_valid = 1'b0;

        // Write pointer wrap, followed by a short POOL sweep
        do_cmd(12'hFFE, 4, 8'h10, 2, POOL, 16'h00C1, 4, 1'b1);
        stream(16'h00C1, 4, 16'hFFFF, 1);
        drain();

        // Run only, read pointer wraps
        do_cmd(12'h000, 0, 8'hFE, 3, CONV, 16'h0000, 0, 1'b1);
        chk("run_in_ready", 64'(bus_if.in_ready), 64'(0));
        drain();

        // Zero-length command
        do_cmd(12'h123, 0, 8'h45, 0, CONV, 16'h0000, 0, 1'b1);
        chk("zl_cmd_ready_done", 64'(bus_if.cmd_ready), 64'(0));
        chk("zl_busy_done",      64'(bus_if.busy),      64'(1));
        step();
        chk("zl_cmd_ready_after", 64'(bus_if.cmd_ready), 64'(1));
        chk("zl_done",            64'(bus_if.done),      64'(1));
        drain();

        // Reset after three of eight beats, then a fresh command
        do_cmd(12'h200, 8, 8'h00, 0, INVALID, 16'h00D1, 3, 1'b0);
        stream(16'h00D1, 3, 16'hFFFF, 1);
        reset = 1'b1;
        step();
        chk("mid_rst_pk",        64'(bus_if.CNTR_pk_out), 64'(0));
        chk("mid_rst_done",      64'(bus_if.done),        64'(0));
        chk("mid_rst_busy",      64'(bus_if.busy),        64'(0));
        chk("mid_rst_cmd_ready", 64'(bus_if.cmd_ready),   64'(1));
        chk("mid_rst_in_ready",  64'(bus_if.in_ready),    64'(0));
        reset = 1'b0;
        step();
        chk("mid_rst_sb", 64'(sb.size()), 64'(0));
        do_cmd(12'h100, 2, 8'h00, 0, INVALID, 16'h00E1, 2, 1'b1);
        stream(16'h00E1, 2, 16'hFFFF, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cntr_load_seq.md
Name: cntr_load_seq

Overview:
- Main-controller sequencer that sits directly upstream of the buffer write decoder and produces its input packet (CNTR_PACKET).
- Accepts one load/compute command at a time.
- LOAD phase: streams input words (valid/ready) into consecutive global buffer addresses.
- RUN phase: sweeps the read address for the PE array. Signals completion with a one-cycle pulse.

Parameters:
- DATA_WID, `CNN_XLEN (default 16): data word width.
- ICP_NUM, `ICP_NUM (default 4): input-channel buffers per output-channel group.
- ICP_B, $clog2(ICP_NUM): ICP select bits.
- OCP_NUM, `OCP_NUM (default 4): output-channel groups.
- OCP_B, $clog2(OCP_NUM): OCP select bits.
- ADDR_B, `ADDR_B (default 8): local word-address bits per buffer.
- GADDR_B, ADDR_B+ICP_B+OCP_B: global write-address bits.
- LEN_B, GADDR_B+1: command length bits, so that a full sweep of 2^GADDR_B words is expressible.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: command offered.
- cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready.
- cmd_wr_base, input, GADDR_B: first global write address.
- cmd_wr_len, input, LEN_B: number of words to load.
- cmd_rd_base, input, ADDR_B: first read address.
- cmd_rd_len, input, ADDR_B+1: number of read cycles.
- cmd_pe_state, input, PE_STATE: PE state driven during RUN.
- in_valid, input, 1: stream word valid.
- in_ready, output, 1: stream word accepted when in_valid && in_ready.
- in_data, input, DATA_WID: stream word.
- CNTR_pk_out, output, CNTR_PACKET: the packet consumed by the decoder. Fields: PE_state, wrb, wrb_addr[GADDR_B], wrb_data[DATA_WID], rdb_addr[ADDR_B].
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - state=IDLE.
  - CNTR_pk_out.PE_state=INVALID; wrb=0; wrb_addr=0; wrb_data=0; rdb_addr=0.
  - done=0, busy=0.
  - Counters cleared.
  - Reset asserted mid-LOAD or mid-RUN aborts immediately. No further wrb pulses occur, and the partially loaded data is abandoned.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cmd_ready=1, in_ready=0.
  - On cmd handshake, latch all cmd fields. Then go to LOAD if cmd_wr_len!=0, else RUN if cmd_rd_len!=0, else DONE.
- LOAD:
  - in_ready=1, cmd_ready=0.
  - Each accepted beat registers one write: wrb=1, wrb_data=in_data, wrb_addr=wr_ptr, PE_state=LOAD.
  - The beat accepted in cycle N is visible on CNTR_pk_out in cycle N+1 (latency 1).
  - wr_ptr increments modulo 2^GADDR_B. Wrap from all-ones to 0 is legal and silent.
  - Cycles without a beat: wrb=0, other fields hold.
  - When the last beat is accepted (remaining count 1→0), go to RUN if rd_len!=0, else DONE. in_ready drops in the following cycle; no extra beat may be accepted.
- RUN:
  - in_ready=0, wrb=0.
  - Each cycle drives PE_state=latched cmd_pe_state and rdb_addr=rd_ptr (registered).
  - rd_ptr starts at cmd_rd_base and increments modulo 2^ADDR_B.
  - Runs exactly rd_len cycles, then goes to DONE.
- DONE: done=1 for one cycle, PE_state=INVALID, then IDLE.
- A new command cannot be accepted in the DONE cycle.
- in_valid asserted outside LOAD is ignored and never stalls the FSM.
- busy = (state!=IDLE).
- wrb_data and rdb_addr hold their last values when not updated. Only wrb and PE_state are qualifiers.

Decomposition:
- Shared package holds:
  - PE_STATE enum (INVALID, LOAD, CONV, POOL, …).
  - CNTR_PACKET and DEC_OUT_PACKET structs.
  - `CNN_XLEN, `ICP_NUM, `OCP_NUM, `ADDR_B, `SD.
  - The FSM state enum, local to this block's package section.
- One natural sub-module: addr_ctr. It is a loadable up-counter with length countdown and a last flag. Parameterised on width, instantiated twice (write pointer GADDR_B, read pointer ADDR_B).

Test Plan:
- Basic load: cmd wr_base=0x00E, wr_len=4, rd_len=0; in_valid held high with data 0xA1..0xA4. Required response:
  - wrb=1 on 4 consecutive cycles with addr 0x00E, 0x00F, 0x010, 0x011 and data 0xA1..0xA4.
  - done pulses 1 cycle after the last write. in_ready low thereafter.
- Backpressure gaps: wr_len=3, in_valid pattern 1,0,0,1,0,1 → exactly 3 wrb pulses at addrs base, base+1, base+2. wrb=0 in the gap cycles.
- Wrap: wr_base=0xFFE (GADDR_B=12), wr_len=4 → addrs 0xFFE, 0xFFF, 0x000, 0x001.
- Run phase: wr_len=0, rd_base=0xFE, rd_len=3, pe_state=CONV → no wrb. rdb_addr 0xFE, 0xFF, 0x00 with PE_state=CONV for exactly 3 cycles, then done=1, PE_state=INVALID.
- Zero-length command: wr_len=0, rd_len=0 → DONE the next cycle, done pulse, no wrb. cmd_ready low during DONE and high again after.
- Reset mid-LOAD: wr_len=8, reset asserted after 3 beats → next cycle all outputs are at reset values and cmd_ready=1. A fresh command then writes from its own base.
